// File: rtl/inst_line_buf.sv
// Single-line instruction buffer on the ROM fetch port. Hits are served combinationally. Misses hold stallreq_o high while the line fills.
// The fill uses a req/gnt handshake with burst beats that may have gaps. INST_BUF_STAT_EN adds miss_cnt_o.
module inst_line_buf #(
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  output logic        stallreq_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
`ifdef INST_BUF_STAT_EN
  ,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int IW = $clog2(LINE_WORDS);
  localparam int OW = IW + 2;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, FILL = 2'd2} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [31:0]     r_buf [LINE_WORDS];
  logic [31-OW:0]  r_tag;
  logic            r_valid;
  logic [IW-1:0]   r_cnt;

  logic [IW-1:0]   w_index;
  logic [31-OW:0]  w_tag;
  logic            w_hit;
  logic            w_start;
  logic            w_gnt;
  logic            w_beat;
  logic            w_last;

  assign w_index = rom_addr_i[OW-1:2];
  assign w_tag   = rom_addr_i[31:OW];
  assign w_hit   = r_valid && (w_tag == r_tag);
  assign w_start = (r_state == IDLE) && rom_ce_i && !w_hit;
  assign w_gnt   = (r_state == REQ) && mem_gnt_i;
  assign w_beat  = (r_state == FILL) && mem_rvalid_i;
  assign w_last  = w_beat && (r_cnt == IW'(LINE_WORDS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = REQ;
      REQ:     if (w_gnt)   w_next = FILL;
      FILL:    if (w_last)  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Reset forces both fetch outputs low even when rom_ce_i is high.
  always_comb begin
    rom_data_o = '0;
    stallreq_o = 1'b0;
    if (rst && rom_ce_i) begin
      if (r_state == IDLE && w_hit) rom_data_o = r_buf[w_index];
      else                          stallreq_o = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= 1'b0;
      r_cnt      <= '0;
      r_tag      <= '0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
    end else begin
      if (w_start) begin
        mem_addr_o <= {w_tag, {OW{1'b0}}};
        mem_req_o  <= 1'b1;
        r_valid    <= 1'b0;
        r_cnt      <= '0;
      end
      if (w_gnt) mem_req_o <= 1'b0;
      if (w_beat) begin
        r_cnt <= r_cnt + IW'(1);
        if (w_last) begin
          r_tag   <= mem_addr_o[31:OW];
          r_valid <= 1'b1;
        end
      end
    end
  end

  // Line storage needs no reset: r_valid gates every read.
  always_ff @(posedge clk) begin
    if (w_beat) r_buf[r_cnt] <= mem_rdata_i;
  end

`ifdef INST_BUF_STAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         miss_cnt_o <= '0;
    else if (w_start) miss_cnt_o <= miss_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_inst_line_buf.sv
// Scoreboard bench for inst_line_buf. The driver issues fetches and queues the expected word and stall length from a resident-line model.
// A responder emulates backing memory. The monitor checks each served fetch.
module tb_inst_line_buf;
  localparam int LW = 4;
  localparam logic [31:0] MASK = ~32'(LW * 4 - 1);

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        stallreq_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
`ifdef INST_BUF_STAT_EN
  logic [31:0] miss_cnt_o;
`endif

  inst_line_buf #(.LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i),
    .rom_data_o(rom_data_o), .stallreq_o(stallreq_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
`ifdef INST_BUF_STAT_EN
    , .miss_cnt_o(miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          stall;
  } exp_t;

  exp_t        exp_q[$];
  int          cfg_q[$];
  logic [31:0] base_q[$];
  int          errors = 0;
  int          checks = 0;
  logic        res_vld;
  logic [31:0] res_base;
  int          model_miss;
  logic        resp_busy = 1'b0;

  // Backing memory contents: line 0 holds 0x11..0x44, everything else is an odd-multiplier hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w < 32'h10) return (32'(w[3:2]) + 32'd1) * 32'h11;
    return (w * 32'h9E37_79B1) ^ 32'hC3A5_0F17;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Plans one line fill: grant delay, per-beat gaps, and the resulting stall length.
  task automatic plan_fill(input logic [31:0] a, input int g_in, input int gi, input int gv,
                           input bit rnd, output int st);
    int g;
    int gp;
    g  = rnd ? int'($urandom_range(0, 2)) : g_in;
    st = 2 + LW + g;
    cfg_q.push_back(g);
    for (int i = 0; i < LW; i++) begin
      gp = rnd ? int'($urandom_range(0, 1)) : ((i == gi) ? gv : 0);
      cfg_q.push_back(gp);
      st += gp;
    end
    base_q.push_back(a & MASK);
    res_vld  = 1'b1;
    res_base = a & MASK;
    model_miss++;
  endtask

  task automatic wait_served();
    int n;
    n = 0;
    @(negedge clk);
    while (stallreq_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (stallreq_o) begin
      checks++;
      errors++;
      $display("FAIL served_timeout: addr %h still stalled after %0d cycles, required stall to drop", rom_addr_i, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input int g, input int gi, input int gv, input bit rnd);
    int st;
    if (res_vld && res_base == (a & MASK)) st = 0;
    else plan_fill(a, g, gi, gv, rnd, st);
    exp_q.push_back('{mem_word(a), st});
    rom_ce_i   = 1'b1;
    rom_addr_i = a;
    wait_served();
  endtask

  // Backing memory responder.
  initial begin
    logic [31:0] base;
    int g;
    int gp;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req_o === 1'b1) begin
        resp_busy = 1'b1;
        checks++;
        if (base_q.size() == 0) begin
          errors++;
          $display("FAIL mem_addr: unexpected fill at %h, required no fill", mem_addr_o);
          base = mem_addr_o;
        end else begin
          base = base_q.pop_front();
          if (mem_addr_o !== base) begin
            errors++;
            $display("FAIL mem_addr: got %h, required %h", mem_addr_o, base);
          end
        end
        g = (cfg_q.size() > 0) ? cfg_q.pop_front() : 0;
        repeat (g) begin @(posedge clk); #1; end
        mem_gnt_i = 1'b1;
        @(posedge clk);
        #1;
        mem_gnt_i = 1'b0;
        for (int i = 0; i < LW; i++) begin
          gp = (cfg_q.size() > 0) ? cfg_q.pop_front() : 0;
          repeat (gp) begin @(posedge clk); #1; end
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = mem_word(base + 32'(4 * i));
          @(posedge clk);
          #1;
          mem_rvalid_i = 1'b0;
        end
        resp_busy = 1'b0;
      end
    end
  end

  // Monitor: counts stall cycles, and pops and compares on every served fetch.
  int   stall_run = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      stall_run = 0;
    end else if (rom_ce_i) begin
      if (stallreq_o) begin
        stall_run++;
      end else begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL serve: unexpected serve of %h data %h, required none", rom_addr_i, rom_data_o);
        end else begin
          mon_e = exp_q.pop_front();
          checks += 2;
          if (rom_data_o !== mon_e.data) begin
            errors++;
            $display("FAIL rom_data @%h: got %h, required %h", rom_addr_i, rom_data_o, mon_e.data);
          end
          if (stall_run != mon_e.stall) begin
            errors++;
            $display("FAIL stall_cycles @%h: got %0d, required %0d", rom_addr_i, stall_run, mon_e.stall);
          end
        end
        stall_run = 0;
      end
    end else begin
      checks++;
      if (rom_data_o !== 32'h0 || stallreq_o !== 1'b0 || mem_req_o !== 1'b0) begin
        errors++;
        $display("FAIL ce_low: data %h stall %b req %b, required 0 0 0", rom_data_o, stallreq_o, mem_req_o);
      end
      stall_run = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int s1;
    int s2;
    int n;
    rst        = 1'b0;
    rom_ce_i   = 1'b1;
    rom_addr_i = 32'h0;
    res_vld    = 1'b0;
    res_base   = '0;
    model_miss = 0;
    @(negedge clk);
    chk("reset_rom_data", rom_data_o, 32'h0);
    chk("reset_stallreq", 32'(stallreq_o), 32'h0);
    chk("reset_mem_req", 32'(mem_req_o), 32'h0);
    chk("reset_mem_addr", mem_addr_o, 32'h0);
`ifdef INST_BUF_STAT_EN
    chk("reset_miss_cnt", miss_cnt_o, 32'h0);
`endif
    @(posedge clk);
    #1;
    rom_ce_i = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;

    // First fill of line 0, then hits on the rest of the line.
    fetch(32'h0, 0, -1, 0, 1'b0);
    fetch(32'h4, 0, -1, 0, 1'b0);
    fetch(32'h8, 0, -1, 0, 1'b0);
    fetch(32'hC, 0, -1, 0, 1'b0);

    // Line replacement, then line 0 misses again.
    fetch(32'h10, 0, -1, 0, 1'b0);
    fetch(32'h0, 0, -1, 0, 1'b0);
`ifdef INST_BUF_STAT_EN
    chk("miss_cnt_after_3", miss_cnt_o, 32'd3);
`endif

    // Grant delayed by 3 cycles plus one idle cycle before beat 2.
    fetch(32'h40, 3, 2, 1, 1'b0);
    fetch(32'h48, 0, -1, 0, 1'b0);

    rom_ce_i = 1'b0;
    repeat (6) begin
      rom_addr_i = $urandom;
      @(posedge clk);
      #1;
    end

    // Reset after beat 2; beat 3 then arrives while idle and must be dropped.
    plan_fill(32'h80, 0, 3, 3, 1'b0, s1);
    rom_addr_i = 32'h80;
    rom_ce_i   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst        = 1'b0;
    rom_ce_i   = 1'b0;
    res_vld    = 1'b0;
    model_miss = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    n = 0;
    while (resp_busy && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("responder_idle", 32'(resp_busy), 32'h0);
    repeat (2) begin @(posedge clk); #1; end
    fetch(32'h84, 0, -1, 0, 1'b0);
`ifdef INST_BUF_STAT_EN
    chk("miss_cnt_after_reset", miss_cnt_o, 32'd1);
`endif

    // Address moves to line 0x20 mid-fill of line 0x0: both fills run back to back.
    plan_fill(32'h0, 0, -1, 0, 1'b0, s1);
    plan_fill(32'h20, 0, -1, 0, 1'b0, s2);
    exp_q.push_back('{mem_word(32'h24), s1 + s2});
    rom_ce_i   = 1'b1;
    rom_addr_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rom_addr_i = 32'h24;
    wait_served();
    fetch(32'h0, 0, -1, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rom_ce_i   = 1'b0;
        rom_addr_i = $urandom;
        @(posedge clk);
        #1;
      end else begin
        fetch(32'($urandom_range(0, 255)), 0, -1, 0, 1'b1);
      end
    end

    rom_ce_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
`ifdef INST_BUF_STAT_EN
    chk("miss_cnt_final", miss_cnt_o, 32'(model_miss));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
